// File: rtl/demux_scan_pkg.sv
// Shared types and default sizes for the demux scan sequencer.
//   ST_*          scan FSM state encoding
//   DEF_SEL_W     default select width (channel count = 2**DEF_SEL_W)
//   DEF_NCH       default channel count
//   DEF_DWELL_W   default width of the dwell-time input
package demux_scan_pkg;

    localparam int unsigned DEF_SEL_W   = 4;
    localparam int unsigned DEF_NCH     = 1 << DEF_SEL_W;
    localparam int unsigned DEF_DWELL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRIVE = 2'd2,
        ST_GAP   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/demux_next_chan.sv
// Combinational next-enabled-channel finder.
//   mask        enabled-channel bitmap
//   cur         currently selected channel
//   nxt         lowest enabled channel strictly above cur (valid when found_above)
//   found_above 1 when such a channel exists
//   first       lowest enabled channel overall (wrap target)
module demux_next_chan
    import demux_scan_pkg::*;
#(
    parameter  int unsigned SEL_W = DEF_SEL_W,
    localparam int unsigned NCH   = 1 << SEL_W
) (
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] nxt,
    output logic             found_above,
    output logic [SEL_W-1:0] first
);

    // Descending walk: the last hit written is the lowest matching index.
    always_comb begin
        nxt         = '0;
        first       = '0;
        found_above = 1'b0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first = SEL_W'(i);
                if (i > int'(cur)) begin
                    nxt         = SEL_W'(i);
                    found_above = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Upstream sequencer for the 1x16 demux: walks enabled channels in ascending
// order, holding in=1 for dwell+1 cycles each, with break-before-make gaps.
//   clk, rst   clock, synchronous active-high reset
//   start      scan request (sampled in IDLE only)
//   stop       abort, highest priority
//   cont       continuous (wrapping) scan, latched at start
//   dwell      drive cycles per channel minus one, latched at start
//   chan_mask  enabled channels, latched at start
//   in, sel    data line and select bus to the demux
//   busy       high whenever not IDLE
//   done       one-cycle pulse at the end of a one-shot scan (or empty mask)
module demux_scan_ctrl
    import demux_scan_pkg::*;
#(
    parameter  int unsigned SEL_W   = DEF_SEL_W,
    parameter  int unsigned DWELL_W = DEF_DWELL_W,
    localparam int unsigned NCH     = 1 << SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NCH-1:0]     chan_mask,
    output logic               in,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               done
);

    scan_state_t          r_state;
    logic [NCH-1:0]       r_mask;
    logic [DWELL_W-1:0]   r_dwell;
    logic [DWELL_W-1:0]   r_cnt;
    logic                 r_cont;
    logic                 r_in;
    logic [SEL_W-1:0]     r_sel;
    logic                 r_busy;
    logic                 r_done;

    logic [NCH-1:0]       w_mask;
    logic [SEL_W-1:0]     w_nxt;
    logic [SEL_W-1:0]     w_first;
    logic                 w_found_above;

    // In IDLE the finder looks at the live mask to pick the first channel.
    assign w_mask = (r_state == ST_IDLE) ? chan_mask : r_mask;

    demux_next_chan #(.SEL_W(SEL_W)) u_next_chan (
        .mask        (w_mask),
        .cur         (r_sel),
        .nxt         (w_nxt),
        .found_above (w_found_above),
        .first       (w_first)
    );

    // Scan FSM; in and sel change only on the same edge that drops in,
    // so sel is never moved while the demux is being driven.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_cont  <= 1'b0;
            r_in    <= 1'b0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_state <= ST_IDLE;
                r_in    <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            if (chan_mask != '0) begin
                                r_mask  <= chan_mask;
                                r_dwell <= dwell;
                                r_cont  <= cont;
                                r_sel   <= w_first;
                                r_busy  <= 1'b1;
                                r_state <= ST_SETUP;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    ST_SETUP: begin
                        r_in    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_DRIVE;
                    end
                    ST_DRIVE: begin
                        if (r_cnt == r_dwell) begin
                            r_in    <= 1'b0;
                            r_state <= ST_GAP;
                            if (w_found_above) begin
                                r_sel <= w_nxt;
                            end else if (r_cont) begin
                                r_sel <= w_first;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + DWELL_W'(1);
                        end
                    end
                    ST_GAP: begin
                        // r_done marks the final gap of a one-shot scan.
                        if (r_done) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_in    <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= ST_DRIVE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign in   = r_in;
    assign sel  = r_sel;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Directed bench for demux_scan_ctrl with a per-cycle expected trace and a
// demux output scoreboard.
module tb_demux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        cont;
    logic [7:0]  dwell;
    logic [15:0] chan_mask;
    logic        in;
    logic [3:0]  sel;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;

    logic       prev_in;
    logic [3:0] prev_sel;
    logic [3:0] last_sel;

    demux_scan_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .dwell     (dwell),
        .chan_mask (chan_mask),
        .in        (in),
        .sel       (sel),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare {busy,done,in,sel} and the demux output against expected values.
    task automatic cyc(input string tag, input logic b, input logic d, input logic i, input logic [3:0] s);
        logic [15:0] y_dut;
        logic [15:0] y_exp;
        y_dut = 16'(in) << sel;
        y_exp = 16'(i) << s;
        check(tag, {25'd0, busy, done, in, sel}, {25'd0, b, d, i, s});
        check({tag, "_y"}, {16'd0, y_dut}, {16'd0, y_exp});
    endtask

    // Start a scan and check every cycle of it. With noise=1 the inputs are
    // scrambled (and start re-pulsed) during DRIVE; all of that must be ignored.
    task automatic scan(input string tag, input logic [15:0] m, input logic [7:0] dw,
                        input logic c, input int visits, input logic noise);
        int ch[$];
        int cur;
        int nx;
        logic last;
        for (int i = 0; i < 16; i++) if (m[i]) ch.push_back(i);
        chan_mask = m; dwell = dw; cont = c; start = 1'b1;
        step();
        start = 1'b0;
        cyc({tag, "_setup"}, 1'b1, 1'b0, 1'b0, 4'(ch[0]));
        cur = ch[0];
        for (int v = 0; v < visits; v++) begin
            cur = ch[v % ch.size()];
            for (int d = 0; d <= int'(dw); d++) begin
                if (noise) begin
                    start = 1'b1; chan_mask = ~m; dwell = 8'd0; cont = ~c;
                end
                step();
                cyc({tag, "_drive"}, 1'b1, 1'b0, 1'b1, 4'(cur));
            end
            start = 1'b0; chan_mask = m; dwell = dw; cont = c;
            step();
            last = !c && (v == visits - 1);
            nx   = last ? cur : ch[(v + 1) % ch.size()];
            cyc({tag, "_gap"}, 1'b1, last, 1'b0, 4'(nx));
        end
        if (!c) begin
            step();
            cyc({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 4'(cur));
        end
        last_sel = 4'(c ? ch[visits % ch.size()] : cur);
    endtask

    // Break-before-make invariant: sel may not move between two driven cycles.
    always @(negedge clk) begin
        if (!rst && in && prev_in) check("sel_stable", {28'd0, sel}, {28'd0, prev_sel});
        prev_in  <= in;
        prev_sel <= sel;
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
        dwell = 8'd0; chan_mask = 16'd0;
        prev_in = 1'b0; prev_sel = 4'd0; last_sel = 4'd0;

        // 1: reset held for two cycles
        step(); cyc("reset0", 1'b0, 1'b0, 1'b0, 4'd0);
        step(); cyc("reset1", 1'b0, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        step(); cyc("post_reset", 1'b0, 1'b0, 1'b0, 4'd0);

        // 2: full one-shot scan, dwell 0
        scan("full", 16'hFFFF, 8'd0, 1'b0, 16, 1'b0);

        // 3: sparse mask, dwell 3 (21 busy cycles)
        scan("sparse", 16'h8421, 8'd3, 1'b0, 4, 1'b0);

        // 4: continuous wrap 1,2,1,2 then stop during the next DRIVE
        scan("cont", 16'h0006, 8'd1, 1'b1, 4, 1'b0);
        step(); cyc("cont_drive", 1'b1, 1'b0, 1'b1, 4'd1);
        stop = 1'b1;
        step(); stop = 1'b0;
        cyc("stop", 1'b0, 1'b0, 1'b0, 4'd1);
        step(); cyc("stop_idle", 1'b0, 1'b0, 1'b0, 4'd1);

        // 5a: empty mask -> done next cycle, never busy or driving
        chan_mask = 16'd0; start = 1'b1;
        step(); start = 1'b0;
        cyc("empty_done", 1'b0, 1'b1, 1'b0, 4'd1);
        step(); cyc("empty_after", 1'b0, 1'b0, 1'b0, 4'd1);

        // 5b: start/mask/dwell/cont churn while busy has no effect
        scan("busy_ign", 16'h0030, 8'd2, 1'b0, 2, 1'b1);

        // 5c: stop and start together in IDLE -> stop wins
        chan_mask = 16'h0100; start = 1'b1; stop = 1'b1;
        step(); start = 1'b0; stop = 1'b0;
        cyc("stop_start", 1'b0, 1'b0, 1'b0, 4'd5);
        step(); cyc("stop_start2", 1'b0, 1'b0, 1'b0, 4'd5);

        // 5d: single channel continuous toggles on the same sel
        scan("single", 16'h0800, 8'd2, 1'b1, 3, 1'b0);
        stop = 1'b1; step(); stop = 1'b0;
        cyc("single_stop", 1'b0, 1'b0, 1'b0, 4'd11);

        // 5e: reset during DRIVE
        chan_mask = 16'h0010; dwell = 8'd5; cont = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        cyc("rst_setup", 1'b1, 1'b0, 1'b0, 4'd4);
        step(); cyc("rst_drive", 1'b1, 1'b0, 1'b1, 4'd4);
        rst = 1'b1;
        step(); cyc("rst_mid", 1'b0, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        step(); cyc("rst_after", 1'b0, 1'b0, 1'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
